// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame buffer constants, pixel and column descriptor types
package fb_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;
  localparam int PIXEL_WIDTH   = 16;
  localparam int SETTLE_CYCLES = 2;

  typedef logic [PIXEL_WIDTH-1:0] rgb565_t;

  localparam rgb565_t CEILING_COLOR = 16'h4208;
  localparam rgb565_t FLOOR_COLOR   = 16'h8410;

  localparam logic [8:0]  X_LIMIT     = 9'(SCREEN_WIDTH);
  localparam logic [15:0] ROW_STRIDE  = 16'(SCREEN_WIDTH);
  localparam logic [7:0]  ROWS        = 8'(SCREEN_HEIGHT);
  localparam logic [1:0]  SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] height;
    rgb565_t    color;
    logic       last;
  } col_desc_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    WAIT_SWAP = 2'd2,
    SETTLE    = 2'd3
  } writer_state_e;

endpackage

// File: rtl/column_span_calc.sv
// rtl/column_span_calc.sv - clamps wall height and centres it vertically (top/bot rows)
module column_span_calc
  import fb_pkg::*;
(
  input  logic [7:0] height_i,
  output logic [7:0] top_o,
  output logic [7:0] bot_o
);

  logic [7:0] h_clamped;

  assign h_clamped = (height_i >= ROWS) ? ROWS : height_i;
  assign top_o     = (ROWS - h_clamped) >> 1;
  assign bot_o     = top_o + h_clamped;

endmodule

// File: rtl/column_pixel_writer.sv
// rtl/column_pixel_writer.sv - expands column descriptors into per-row frame buffer writes
module column_pixel_writer
  import fb_pkg::*;
(
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [8:0]  col_x_in,
  input  logic [7:0]  col_height_in,
  input  logic [15:0] col_color_in,
  input  logic        col_last_in,
  input  logic        video_last_pixel_in,
  output logic [15:0] ray_address_out,
  output logic [15:0] ray_pixel_out,
  output logic        ray_last_pixel_out,
  output logic        busy_out
);

  writer_state_e state_q, state_d;
  logic [7:0]    y_q, y_d;
  logic [15:0]   addr_cnt_q, addr_cnt_d;
  logic [7:0]    top_q, top_d, bot_q, bot_d;
  rgb565_t       color_q, color_d;
  logic          col_last_q, col_last_d;
  logic [15:0]   addr_q, addr_d;
  rgb565_t       pixel_q, pixel_d;
  logic          ray_last_q, ray_last_d;
  logic [1:0]    settle_q, settle_d;
  logic          video_seen_q, video_seen_d;

  col_desc_t  col_in;
  logic [7:0] span_top, span_bot;

  assign col_in = '{x: col_x_in, height: col_height_in, color: col_color_in, last: col_last_in};

  column_span_calc u_span (
    .height_i (col_in.height),
    .top_o    (span_top),
    .bot_o    (span_bot)
  );

  assign col_ready_out      = (state_q == IDLE);
  assign busy_out           = (state_q != IDLE);
  assign ray_address_out    = addr_q;
  assign ray_pixel_out      = pixel_q;
  assign ray_last_pixel_out = ray_last_q;

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    addr_cnt_d   = addr_cnt_q;
    top_d        = top_q;
    bot_d        = bot_q;
    color_d      = color_q;
    col_last_d   = col_last_q;
    addr_d       = addr_q;
    pixel_d      = pixel_q;
    ray_last_d   = 1'b0;
    settle_d     = settle_q;
    video_seen_d = video_seen_q | video_last_pixel_in;

    case (state_q)
      IDLE: begin
        if (col_valid_in) begin
          top_d      = span_top;
          bot_d      = span_bot;
          color_d    = col_in.color;
          col_last_d = col_in.last;
          // Off-screen columns produce no writes; only a sweep-ending flag survives.
          if (col_in.x >= X_LIMIT) begin
            if (col_in.last) begin
              ray_last_d = 1'b1;
              state_d    = WAIT_SWAP;
            end
          end else begin
            y_d        = 8'd0;
            addr_cnt_d = 16'(col_in.x);
            state_d    = EMIT;
          end
        end
      end
      EMIT: begin
        // y_q == ROWS is the cycle in which the final row is on the outputs.
        if (y_q == ROWS) begin
          state_d = col_last_q ? WAIT_SWAP : IDLE;
        end else begin
          addr_d     = addr_cnt_q;
          addr_cnt_d = addr_cnt_q + ROW_STRIDE;
          y_d        = y_q + 8'd1;
          if (y_q < top_q)      pixel_d = CEILING_COLOR;
          else if (y_q < bot_q) pixel_d = color_q;
          else                  pixel_d = FLOOR_COLOR;
          ray_last_d = col_last_q && (y_q == ROWS - 8'd1);
        end
      end
      WAIT_SWAP: begin
        if (video_seen_q || video_last_pixel_in) begin
          state_d      = SETTLE;
          settle_d     = 2'd0;
          video_seen_d = 1'b0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = IDLE;
        else                         settle_d = settle_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      y_q          <= '0;
      addr_cnt_q   <= '0;
      top_q        <= '0;
      bot_q        <= '0;
      color_q      <= '0;
      col_last_q   <= 1'b0;
      addr_q       <= '0;
      pixel_q      <= '0;
      ray_last_q   <= 1'b0;
      settle_q     <= '0;
      video_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      addr_cnt_q   <= addr_cnt_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      color_q      <= color_d;
      col_last_q   <= col_last_d;
      addr_q       <= addr_d;
      pixel_q      <= pixel_d;
      ray_last_q   <= ray_last_d;
      settle_q     <= settle_d;
      video_seen_q <= video_seen_d;
    end
  end

endmodule

// File: tb/tb_column_pixel_writer.sv
// tb/tb_column_pixel_writer.sv - scoreboard bench for column_pixel_writer
module tb_column_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        col_valid = 1'b0;
  logic        col_ready;
  logic [8:0]  col_x = '0;
  logic [7:0]  col_height = '0;
  logic [15:0] col_color = '0;
  logic        col_last = 1'b0;
  logic        video = 1'b0;
  logic [15:0] ray_addr;
  logic [15:0] ray_pix;
  logic        ray_last;
  logic        busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_cnt = 0;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] pix;
    logic        last;
  } exp_t;

  exp_t sb[$];

  column_pixel_writer dut (
    .pixel_clk_in        (clk),
    .rst_in              (rst),
    .col_valid_in        (col_valid),
    .col_ready_out       (col_ready),
    .col_x_in            (col_x),
    .col_height_in       (col_height),
    .col_color_in        (col_color),
    .col_last_in         (col_last),
    .video_last_pixel_in (video),
    .ray_address_out     (ray_addr),
    .ray_pixel_out       (ray_pix),
    .ray_last_pixel_out  (ray_last),
    .busy_out            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ray_last) last_cnt++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_addr", 32'(ray_addr), 32'(e.addr));
      check("sb_pix", 32'(ray_pix), 32'(e.pix));
      check("sb_last", 32'(ray_last), 32'(e.last));
    end
  end

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [8:0] x, input logic [7:0] h, input logic [15:0] c,
                      input logic l, output int acc);
    int n;
    int hc;
    int top;
    int bot;
    n = 0;
    while (!col_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 1000) check("ready_timeout", 32'(col_ready), 32'd1);
    col_x = x; col_height = h; col_color = c; col_last = l; col_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    col_valid = 1'b0;
    if (x < 9'd320) begin
      hc  = (h > 8'd180) ? 180 : int'(h);
      top = (180 - hc) / 2;
      bot = top + hc;
      for (int y = 0; y < 180; y++) begin
        exp_t e;
        e.cyc  = acc + y + 1;
        e.addr = 16'(int'(x) + 320 * y);
        e.pix  = (y < top) ? 16'h4208 : (y < bot) ? c : 16'h8410;
        e.last = l && (y == 179);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int e;
    step_to(2);
    check("rst_ready", 32'(col_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(ray_addr), 32'd0);
    check("rst_pix", 32'(ray_pix), 32'd0);
    check("rst_last", 32'(ray_last), 32'd0);
    rst = 1'b0;

    // Test 1: basic column with explicit row timing
    send(9'd0, 8'd60, 16'hF800, 1'b0, e);
    step_to(e + 61);
    check("t1_row60_pix", 32'(ray_pix), 32'hF800);
    check("t1_row60_addr", 32'(ray_addr), 32'd19200);
    step_to(e + 180);
    check("t1_ready_low", 32'(col_ready), 32'd0);
    check("t1_final_addr", 32'(ray_addr), 32'd57280);
    step_to(e + 181);
    check("t1_ready_high", 32'(col_ready), 32'd1);
    check("t1_no_last", 32'(last_cnt), 32'd0);

    // Test 2: zero height then clamped oversize height
    send(9'd5, 8'd0, 16'hABCD, 1'b0, e);
    drain();
    send(9'd5, 8'd200, 16'h07E0, 1'b0, e);
    drain();
    check("t2_final_addr", 32'(ray_addr), 32'd57285);
    check("t2_no_last", 32'(last_cnt), 32'd0);

    // Test 3: last column, video pulse mid-sweep
    send(9'd319, 8'd1, 16'h001F, 1'b1, e);
    step_to(e + 50);
    video = 1'b1;
    step_to(e + 51);
    video = 1'b0;
    step_to(e + 181);
    check("t3_last_one_cycle", 32'(ray_last), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    step_to(e + 183);
    check("t3_settle_not_ready", 32'(col_ready), 32'd0);
    step_to(e + 184);
    check("t3_ready", 32'(col_ready), 32'd1);
    check("t3_last_cnt", 32'(last_cnt), 32'd1);

    // Test 4: video pulse long after the last pixel
    send(9'd319, 8'd1, 16'h001F, 1'b1, e);
    step_to(e + 230);
    check("t4_wait_not_ready", 32'(col_ready), 32'd0);
    check("t4_hold_addr", 32'(ray_addr), 32'd57599);
    check("t4_hold_pix", 32'(ray_pix), 32'h8410);
    video = 1'b1;
    step_to(e + 231);
    video = 1'b0;
    step_to(e + 232);
    check("t4_settle_not_ready", 32'(col_ready), 32'd0);
    step_to(e + 233);
    check("t4_ready", 32'(col_ready), 32'd1);
    check("t4_last_cnt", 32'(last_cnt), 32'd2);

    // Test 5: reset in the middle of a column
    send(9'd10, 8'd60, 16'h1234, 1'b0, e);
    step_to(e + 101);
    rst = 1'b1;
    sb.delete();
    step_to(e + 102);
    check("t5_addr", 32'(ray_addr), 32'd0);
    check("t5_pix", 32'(ray_pix), 32'd0);
    check("t5_ready", 32'(col_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    send(9'd7, 8'd180, 16'hF0F0, 1'b0, e);
    drain();

    // Test 6: off-screen columns
    send(9'd400, 8'd0, 16'h1111, 1'b1, e);
    check("t6_last_pulse", 32'(ray_last), 32'd1);
    check("t6_hold_addr", 32'(ray_addr), 32'd57287);
    check("t6_hold_pix", 32'(ray_pix), 32'hF0F0);
    check("t6_wait_busy", 32'(busy), 32'd1);
    step_to(e + 1);
    check("t6_last_one_cycle", 32'(ray_last), 32'd0);
    step_to(e + 3);
    check("t6_still_waiting", 32'(col_ready), 32'd0);
    video = 1'b1;
    step_to(e + 4);
    video = 1'b0;
    send(9'd400, 8'd0, 16'h2222, 1'b0, e);
    check("t6b_ready", 32'(col_ready), 32'd1);
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_addr", 32'(ray_addr), 32'd57287);
    check("t6b_last", 32'(ray_last), 32'd0);
    check("t6_last_cnt", 32'(last_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
